int_arbiter: RTL
================

// Module: int_arbiter
// PURPOSE
//   Prioritised, maskable interrupt arbiter between interrupt sources and the SCPU INT/cause pins.
//   Sources include debounced buttons, the clk_div INT_count tick and the counter outputs.
//   Synchronises each source and latches rising edges into a pending register.
//   Presents the lowest-index enabled pending source to the CPU and tracks in-service state until EOI.
// PARAMETERS
//   N_SRC      8             number of interrupt sources (1..16)
//   CAUSE_BASE 32'h00000010  cause value for source 0; source i reports CAUSE_BASE+i
//   MASK_RST   {N_SRC{1'b1}} mask register value after reset (1 = enabled)
// PORTS
//   clk        in   1      system clock; all state updates on rising edge
//   rst        in   1      synchronous reset, active-high
//   irq_i      in   N_SRC  raw asynchronous interrupt levels
//   mask_we    in   1      write strobe for the mask register
//   mask_din   in   N_SRC  new mask value, taken when mask_we=1
//   int_ack    in   1      one-cycle pulse: CPU has taken the interrupt
//   eoi        in   1      one-cycle pulse: handler finished (mret)
//   INT        out  1      interrupt request to CPU, registered
//   cause      out  32     cause code of the presented/in-service source, registered
//   pending_o  out  N_SRC  pending register
//   mask_o     out  N_SRC  mask register
//   busy       out  1      1 while in SERVICE
// BEHAVIOUR
//   Reset (rst=1 at an edge):
//     INT=0, cause=0, pending=0, mask=MASK_RST, busy=0, state=IDLE.
//     sync1/sync2/sync3 are cleared.
//     rst overrides every other input in that cycle and applies from any state.
//   Synchroniser and edge detect:
//     sync1<=irq_i; sync2<=sync1; sync3<=sync2; rise=sync2&~sync3.
//     Timing: irq_i[i] first sampled high at edge E0 -> pending[i]=1 after E2.
//     A level held high produces exactly one event.
//     A level already high when rst is released produces one event.
//   Pending:
//     Set by rise.
//     Cleared only by int_ack for the selected source.
//     Set and clear on the same source in the same edge -> set wins.
//     A repeat edge on an already-pending source is merged; there is no counting.
//   Mask:
//     On mask_we, mask<=mask_din at that edge.
//     Masked sources still latch pending.
//   FSM, IDLE:
//     If |(pending&mask), sel<=lowest set index, cause<=CAUSE_BASE+sel, INT<=1, go REQ.
//     These updates happen at the same edge, so INT rises one edge after the pending bit is visible.
//     int_ack and eoi are ignored.
//   FSM, REQ:
//     INT=1 and cause are stable.
//     If int_ack: pending[sel]<=0, INT<=0, busy<=1, go SERVICE.
//     Else if mask_we clears mask[sel]: INT<=0, go IDLE; pending[sel] is kept.
//     When int_ack and a mask clear arrive in the same cycle, int_ack wins.
//     A higher-priority arrival does not preempt a presented request.
//     eoi is ignored.
//   FSM, SERVICE:
//     busy=1, INT=0, cause holds.
//     No nesting: new pending sources wait.
//     If eoi: busy<=0, go IDLE; the next selection happens at the following edge.
//     int_ack is ignored.
//   cause holds its last value in IDLE; it changes only on a new selection or on reset.
//   Width and range:
//     cause = CAUSE_BASE + sel, where sel is zero-extended to 32 bits; no wrap is expected.
//     N_SRC>16 is illegal.
// TESTING
//   T1 reset: rst=1 for 2 cycles with irq_i=0
//      -> INT=0, cause=0, pending_o=0, mask_o=8'hFF, busy=0.
//   T2 single: irq_i[2] high for 1 cycle
//      -> pending_o=8'h04 after 2 edges; INT=1 and cause=32'h12 at the next edge;
//      -> int_ack: INT=0, pending_o=0, busy=1; eoi: busy=0.
//   T3 priority: irq_i[5] and irq_i[1] rise together
//      -> cause=32'h11 first; after int_ack+eoi, cause=32'h15 and INT=1 with no new edge.
//   T4 mask: mask_din=8'hFB written, then irq_i[2] pulses
//      -> pending_o=8'h04, INT stays 0; write 8'hFF -> INT=1 next edge, cause=32'h12.
//   T5 withdraw: source 3 in REQ, mask_we clears bit 3
//      -> INT=0 next edge, pending_o[3]=1; repeat with int_ack in the same cycle -> SERVICE, busy=1.
//   T6 level and reset: irq_i[0] held high for 100 cycles -> exactly one ack cycle;
//      -> rst during SERVICE -> busy=0, INT=0, pending_o=0 at the next edge.

Source files
------------

// File: rtl/int_arbiter.sv
// Prioritised, maskable interrupt arbiter: synchronises raw interrupt levels, latches rising
// edges as pending, and presents the lowest-index enabled source to the CPU until EOI.
module int_arbiter #(
  parameter int               N_SRC      = 8,
  parameter logic [31:0]      CAUSE_BASE = 32'h0000_0010,
  parameter logic [N_SRC-1:0] MASK_RST   = {N_SRC{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] irq_i,
  input  logic             mask_we,
  input  logic [N_SRC-1:0] mask_din,
  input  logic             int_ack,
  input  logic             eoi,
  output logic             INT,
  output logic [31:0]      cause,
  output logic [N_SRC-1:0] pending_o,
  output logic [N_SRC-1:0] mask_o,
  output logic             busy,
  output logic [1:0]       state_o
);

  localparam int SEL_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_SERVICE = 2'd2
  } state_e;

  // Handshake: INT is a level held in REQ; the CPU answers with a one-cycle int_ack pulse,
  // which moves the selected source into service; a one-cycle eoi pulse ends service.
  state_e             state_q, state_d;
  logic [N_SRC-1:0]   sync1_q, sync1_d;
  logic [N_SRC-1:0]   sync2_q, sync2_d;
  logic [N_SRC-1:0]   sync3_q, sync3_d;
  logic [N_SRC-1:0]   pending_q, pending_d;
  logic [N_SRC-1:0]   mask_q, mask_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic               int_q, int_d;
  logic [31:0]        cause_q, cause_d;
  logic               busy_q, busy_d;

  logic [N_SRC-1:0]   rise;
  logic [N_SRC-1:0]   cand;
  logic [N_SRC-1:0]   clr;
  logic [SEL_W-1:0]   pick;
  logic               found;

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    int_d     = int_q;
    cause_d   = cause_q;
    busy_d    = busy_q;
    clr       = '0;
    pick      = '0;
    found     = 1'b0;
    sync1_d   = irq_i;
    sync2_d   = sync1_q;
    sync3_d   = sync2_q;
    rise      = sync2_q & ~sync3_q;
    cand      = pending_q & mask_q;
    mask_d    = mask_we ? mask_din : mask_q;

    // Scan downwards so the lowest set index is the one left in pick.
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (cand[i]) begin
        pick  = SEL_W'(i);
        found = 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (found) begin
          sel_d   = pick;
          cause_d = CAUSE_BASE + 32'(pick);
          int_d   = 1'b1;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (int_ack) begin
          clr     = N_SRC'(1) << sel_q;
          int_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = S_SERVICE;
        end else if (mask_we && !mask_din[sel_q]) begin
          int_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      S_SERVICE: begin
        if (eoi) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        int_d   = 1'b0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase

    // A new edge on the source being acknowledged survives the clear.
    pending_d = (pending_q & ~clr) | rise;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      sync1_q   <= '0;
      sync2_q   <= '0;
      sync3_q   <= '0;
      pending_q <= '0;
      mask_q    <= MASK_RST;
      sel_q     <= '0;
      int_q     <= 1'b0;
      cause_q   <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      sync3_q   <= sync3_d;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      sel_q     <= sel_d;
      int_q     <= int_d;
      cause_q   <= cause_d;
      busy_q    <= busy_d;
    end
  end

  assign INT       = int_q;
  assign cause     = cause_q;
  assign pending_o = pending_q;
  assign mask_o    = mask_q;
  assign busy      = busy_q;
  assign state_o   = state_q;

endmodule
